accumulation_writeback_streamer: RTL and testbench

Downstream drain stage for the double-banked accumulation buffer. After a bank switch, it reads the completed bank through the writeback read port (ren_wb/radr_wb/rdata_wb), one word per address 0..num_words-1. It emits the words as a ready/valid output stream toward the ofmap/output interface. It absorbs the buffer's 1-cycle read latency and downstream backpressure with a small FIFO, so no combinational path runs from ofmap_ready to ren_wb.

---
 rtl/accumulation_writeback_streamer_pkg.sv | 20 ++
 rtl/accumulation_writeback_streamer_wb_skid_fifo.sv | 51 +++++
 rtl/accumulation_writeback_streamer.sv | 112 +++++++++++
 tb/tb_accumulation_writeback_streamer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulation_writeback_streamer_pkg.sv
// Shared types and constants for the accumulation-buffer writeback streamer.
// The skid FIFO depth is fixed: three entries cover the read latency plus one stalled word.
package accumulation_writeback_streamer_pkg;

    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] ptr);
        return (ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/accumulation_writeback_streamer_wb_skid_fifo.sv
// Small synchronous FIFO between the writeback read port and the output stream.
// Push and pop in the same cycle are allowed even when full.
module wb_skid_fifo
    import accumulation_writeback_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/accumulation_writeback_streamer.sv
// Drains a completed accumulation bank over the writeback read port into a ready/valid stream.
// state | meaning: IDLE wait for start | READ issuing reads | DRAIN emptying FIFO | DONE one-cycle done pulse
module accumulation_writeback_streamer
    import accumulation_writeback_streamer_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH-1:0] num_words,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    input  logic [DATA_WIDTH-1:0]      rdata_wb,
    output logic [DATA_WIDTH-1:0]      ofmap_data,
    output logic                       ofmap_valid,
    input  logic                       ofmap_ready,
    output logic                       busy,
    output logic                       done
);

    state_t                     state;
    state_t                     state_next;
    logic [BANK_ADDR_WIDTH-1:0] word_cnt;
    logic [BANK_ADDR_WIDTH-1:0] word_cnt_next;
    logic [BANK_ADDR_WIDTH-1:0] issue_next;
    logic                       ren_next;
    logic                       inflight;
    logic                       pop;
    logic [FIFO_CNT_W-1:0]      fifo_count;
    logic [FIFO_CNT_W:0]        count_next;
    logic                       fifo_empty;
    logic                       fifo_full;

    assign ofmap_valid = !fifo_empty;
    assign pop         = ofmap_valid && ofmap_ready;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    // Occupancy after this edge; the issue decision for the next cycle is made from it so ren_wb stays a flop.
    assign count_next  = (FIFO_CNT_W+1)'(fifo_count) + (FIFO_CNT_W+1)'(inflight) - (FIFO_CNT_W+1)'(pop);

    wb_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (rdata_wb),
        .pop       (pop),
        .head      (ofmap_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        issue_next    = radr_wb + BANK_ADDR_WIDTH'(ren_wb);
        ren_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    word_cnt_next = num_words;
                    issue_next    = '0;
                    state_next    = (num_words == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (ren_wb && (radr_wb == word_cnt - BANK_ADDR_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (count_next == '0)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Reads issued now land in the FIFO one cycle later, so ren_wb counts as in flight next cycle.
        ren_next = (state_next == READ) && (issue_next < word_cnt_next) &&
                   ((count_next + (FIFO_CNT_W+1)'(ren_wb)) < (FIFO_CNT_W+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            radr_wb  <= '0;
            ren_wb   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            word_cnt <= word_cnt_next;
            radr_wb  <= issue_next;
            ren_wb   <= ren_next;
            inflight <= ren_wb;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && inflight && !pop));

endmodule

// File: tb/tb_accumulation_writeback_streamer.sv
// Scoreboard bench: a double-banked memory model feeds the read port, expected words are queued at start.
module tb_accumulation_writeback_streamer;

    localparam int DW = 64;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_words = '0;
    logic          ren_wb;
    logic [AW-1:0] radr_wb;
    logic [DW-1:0] rdata_wb = '0;
    logic [DW-1:0] ofmap_data;
    logic          ofmap_valid;
    logic          ofmap_ready = 1'b0;
    logic          busy;
    logic          done;

    accumulation_writeback_streamer #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb),
        .ofmap_data(ofmap_data), .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2][512];
    logic          rd_bank = 1'b0;
    always @(posedge clk) if (ren_wb) rdata_wb <= mem[rd_bank][radr_wb];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx[$];
    int  cur_n = 0, issued = 0, popped = 0, done_cnt = 0, busy_cycles = 0;
    int  start_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ren_wb) begin
                chk("ren_room", 64'(issued - popped < 3), 64'd1);
                chk("ren_in_range", 64'(issued < cur_n), 64'd1);
                chk("radr_order", 64'(radr_wb), 64'(issued));
                issued++;
            end
            if (prev_stall) begin
                chk("valid_held", 64'(ofmap_valid), 64'd1);
                chk("data_stable", ofmap_data, prev_data);
            end
            if (ofmap_valid && ofmap_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_word actual=%h required=none", ofmap_data);
                end else begin
                    chk("word", ofmap_data, exp_q.pop_front());
                end
                rx.push_back(ofmap_data);
                popped++;
                if (popped == 1) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_all_received", 64'(exp_q.size()), 64'd0);
            end
            prev_stall = ofmap_valid && !ofmap_ready;
            prev_data  = ofmap_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ready driver: 0 = always ready, 1 = fixed pattern, 2 = random with rpct percent
    int rmode = 0, rpct = 50, pat_idx = 0;
    logic [7:0] pat = 8'b0110_1001;  // bit i is cycle i of 1,0,0,1,0,1,1,0
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ofmap_ready = 1'b1;
            1:       ofmap_ready = pat[pat_idx % 8];
            default: ofmap_ready = ($urandom_range(0, 99) < rpct);
        endcase
        pat_idx++;
    end

    // Caller is at posedge+#1; start is high for exactly one cycle.
    task automatic issue_start(input int n, input bit expect_accept);
        start = 1'b1;
        num_words = AW'(n);
        if (expect_accept) begin
            exp_q.delete(); rx.delete();
            for (int a = 0; a < n; a++) exp_q.push_back(mem[rd_bank][a]);
            cur_n = n; issued = 0; popped = 0; busy_cycles = 0;
            start_cyc = cyc;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < limit) begin
            @(posedge clk); t++;
        end
        #1;
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done required=done within %0d cycles", name, limit);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input logic bank);
        for (int a = 0; a < 512; a++) mem[bank][a] = {$urandom, $urandom};
    endtask

    initial begin
        int d0;
        fill_random(1'b0);
        fill_random(1'b1);
        #3;
        chk("rst_ren", 64'(ren_wb), 0);
        chk("rst_radr", 64'(radr_wb), 0);
        chk("rst_valid", 64'(ofmap_valid), 0);
        chk("rst_data", ofmap_data, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        #10 rst_n = 1'b1;
        idle(2);

        // basic drain, always ready
        mem[rd_bank][0] = 64'h1111_1111_1111_1111;
        mem[rd_bank][1] = 64'h2222_2222_2222_2222;
        mem[rd_bank][2] = 64'h3333_3333_3333_3333;
        mem[rd_bank][3] = 64'h4444_4444_4444_4444;
        rmode = 0;
        issue_start(4, 1'b1);
        wait_done("basic", 50);
        chk("basic_first_word_cycle", 64'(first_hs_cyc - start_cyc), 64'd3);
        chk("basic_last_word_cycle", 64'(last_hs_cyc - start_cyc), 64'd6);
        chk("basic_done_cycle", 64'(done_cyc - start_cyc), 64'd7);
        chk("basic_busy_cycles", 64'(busy_cycles), 64'd7);
        chk("basic_count", 64'(popped), 64'd4);
        idle(2);

        // backpressure with fixed ready pattern
        for (int a = 0; a < 8; a++) mem[rd_bank][a] = 64'(a) * 64'h0101_0101_0101_0101;
        rmode = 1; pat_idx = 0;
        issue_start(8, 1'b1);
        wait_done("backpressure", 200);
        chk("bp_count", 64'(popped), 64'd8);
        idle(2);

        // zero length
        rmode = 0;
        issue_start(0, 1'b1);
        wait_done("zero", 20);
        chk("zero_done_cycle", 64'(done_cyc - start_cyc), 64'd1);
        chk("zero_busy_cycles", 64'(busy_cycles), 64'd1);
        chk("zero_no_reads", 64'(issued), 64'd0);
        idle(2);

        // start while busy is ignored
        rmode = 2; rpct = 60;
        d0 = done_cnt;
        issue_start(6, 1'b1);
        idle(2);
        issue_start(3, 1'b0);
        wait_done("busy_start", 200);
        idle(10);
        chk("busy_start_count", 64'(popped), 64'd6);
        chk("busy_start_done_pulses", 64'(done_cnt - d0), 64'd1);

        // reset in the middle of a drain
        rmode = 0;
        issue_start(10, 1'b1);
        for (int t = 0; t < 50 && popped < 2; t++) @(posedge clk);
        #1;
        chk("mid_reset_reached", 64'(popped >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_ren", 64'(ren_wb), 0);
        chk("mrst_radr", 64'(radr_wb), 0);
        chk("mrst_valid", 64'(ofmap_valid), 0);
        chk("mrst_data", ofmap_data, 0);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_done", 64'(done), 0);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("mrst_stays_idle", 64'(busy), 0);
        issue_start(2, 1'b1);
        wait_done("post_reset", 50);
        chk("post_reset_count", 64'(popped), 64'd2);

        // bank switch with concurrent writes to the new write bank
        for (int a = 0; a < 8; a++) mem[~rd_bank][a] = {$urandom, $urandom};
        mem[~rd_bank][5] = 64'hCAFE_BABE_CAFE_BABE;
        rd_bank = ~rd_bank;
        rmode = 2; rpct = 50;
        issue_start(6, 1'b1);
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    mem[~rd_bank][k % 8] = {$urandom, $urandom};
                    @(posedge clk); #2;
                end
            end
        join_none
        wait_done("bank_switch", 200);
        chk("bank_switch_count", 64'(popped), 64'd6);
        if (rx.size() > 5) chk("bank_switch_word5", rx[5], 64'hCAFE_BABE_CAFE_BABE);
        idle(14);

        // random lengths, data and ready
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_random(rd_bank);
            rmode = 2; rpct = $urandom_range(20, 100);
            issue_start(n, 1'b1);
            wait_done("random", 2000);
            chk("random_count", 64'(popped), 64'(n));
            idle($urandom_range(0, 3));
        end

        // maximum length
        fill_random(rd_bank);
        rmode = 2; rpct = 85;
        issue_start(511, 1'b1);
        wait_done("max_len", 5000);
        chk("max_len_count", 64'(popped), 64'd511);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
